// File: rtl/mem_wb_regfile.sv
// MEM/WB pipeline register feeding the integer register file.
// Optional debug read port: define REGFILE_DEBUG_PORT_EN.
module mem_wb_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   wd_i,
  input  logic            wreg_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            re1_i,
  input  logic [AW-1:0]   raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic            re2_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata2_o,
  output logic [AW-1:0]   wb_wd_o,
  output logic            wb_wreg_o,
  output logic [XLEN-1:0] wb_wdata_o,
  output logic [63:0]     commit_cnt_o
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [AW-1:0]   dbg_raddr_i,
  output logic [XLEN-1:0] dbg_rdata_o
`endif
);

  logic [XLEN-1:0] rf [NREG];
  logic            commit;

  assign commit = wb_wreg_o && (wb_wd_o != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd_o      <= '0;
      wb_wreg_o    <= 1'b0;
      wb_wdata_o   <= '0;
      commit_cnt_o <= '0;
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else begin
      if (flush_i) begin
        wb_wd_o    <= '0;
        wb_wreg_o  <= 1'b0;
        wb_wdata_o <= '0;
      end else if (!stall_i) begin
        wb_wd_o    <= wd_i;
        wb_wreg_o  <= wreg_i;
        wb_wdata_o <= wdata_i;
      end
      // A stalled entry re-commits every cycle; harmless, but counted.
      if (commit) begin
        rf[wb_wd_o]  <= wb_wdata_o;
        commit_cnt_o <= commit_cnt_o + 64'd1;
      end
    end
  end

  always_comb begin
    if (rst || !re1_i || raddr1_i == '0)
      rdata1_o = '0;
    else if (wb_wreg_o && wb_wd_o == raddr1_i)
      rdata1_o = wb_wdata_o;
    else
      rdata1_o = rf[raddr1_i];
  end

  always_comb begin
    if (rst || !re2_i || raddr2_i == '0)
      rdata2_o = '0;
    else if (wb_wreg_o && wb_wd_o == raddr2_i)
      rdata2_o = wb_wdata_o;
    else
      rdata2_o = rf[raddr2_i];
  end

`ifdef REGFILE_DEBUG_PORT_EN
  always_comb begin
    if (rst || dbg_raddr_i == '0)
      dbg_rdata_o = '0;
    else
      dbg_rdata_o = rf[dbg_raddr_i];
  end
`endif

endmodule

// File: tb/tb_mem_wb_regfile.sv
// Directed bench for mem_wb_regfile (default build).
module tb_mem_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [63:0] wdata_i;
  logic        stall_i;
  logic        flush_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [63:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [63:0] rdata2_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [63:0] wb_wdata_o;
  logic [63:0] commit_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .re1_i        (re1_i),
    .raddr1_i     (raddr1_i),
    .rdata1_o     (rdata1_o),
    .re2_i        (re2_i),
    .raddr2_i     (raddr2_i),
    .rdata2_o     (rdata2_o),
    .wb_wd_o      (wb_wd_o),
    .wb_wreg_o    (wb_wreg_o),
    .wb_wdata_o   (wb_wdata_o),
    .commit_cnt_o (commit_cnt_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic [4:0] wd,
                     input logic we,
                     input logic [63:0] d);
    wd_i    = wd;
    wreg_i  = we;
    wdata_i = d;
  endtask

  initial begin
    rst = 1'b1;
    mem(5'd0, 1'b0, 64'd0);
    stall_i = 0; flush_i = 0;
    re1_i = 1; raddr1_i = 5'd5;
    re2_i = 1; raddr2_i = 5'd5;
    step();
    chk("rd_in_rst", rdata1_o, 64'd0);
    step();
    rst = 1'b0;
    step();

    chk("rst_wd", {59'd0, wb_wd_o}, 64'd0);
    chk("rst_wreg", {63'd0, wb_wreg_o}, 64'd0);
    chk("rst_wdata", wb_wdata_o, 64'd0);
    chk("rst_cnt", commit_cnt_o, 64'd0);
    for (int i = 1; i < 32; i++) begin
      raddr1_i = 5'(i);
      raddr2_i = 5'(i);
      #1;
      chk("rst_rd1", rdata1_o, 64'd0);
      chk("rst_rd2", rdata2_o, 64'd0);
    end

    mem(5'd5, 1'b1, 64'hDEAD_BEEF);
    step();
    mem(5'd0, 1'b0, 64'd0);
    raddr1_i = 5'd5;
    #1;
    chk("byp_x5", rdata1_o, 64'hDEAD_BEEF);
    chk("byp_cnt", commit_cnt_o, 64'd0);
    step();
    chk("rf_x5", rdata1_o, 64'hDEAD_BEEF);
    chk("cnt_1", commit_cnt_o, 64'd1);
    chk("bubble", {63'd0, wb_wreg_o}, 64'd0);

    mem(5'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    mem(5'd0, 1'b0, 64'd0);
    raddr1_i = 5'd0;
    #1;
    chk("x0_byp", rdata1_o, 64'd0);
    step();
    chk("x0_rd", rdata1_o, 64'd0);
    chk("x0_cnt", commit_cnt_o, 64'd1);

    mem(5'd7, 1'b1, 64'h11);
    step();
    stall_i = 1'b1;
    mem(5'd2, 1'b1, 64'h99);
    step();
    chk("stl_wd", {59'd0, wb_wd_o}, 64'd7);
    chk("stl_data", wb_wdata_o, 64'h11);
    chk("stl_cnt1", commit_cnt_o, 64'd2);
    step();
    chk("stl_cnt2", commit_cnt_o, 64'd3);
    step();
    chk("stl_cnt3", commit_cnt_o, 64'd4);
    chk("stl_wreg", {63'd0, wb_wreg_o}, 64'd1);

    flush_i = 1'b1;
    step();
    chk("fl_wreg", {63'd0, wb_wreg_o}, 64'd0);
    chk("fl_wd", {59'd0, wb_wd_o}, 64'd0);
    chk("fl_cnt", commit_cnt_o, 64'd5);
    flush_i = 1'b0;
    stall_i = 1'b0;
    mem(5'd0, 1'b0, 64'd0);
    step();
    chk("fl_cnt2", commit_cnt_o, 64'd5);
    raddr1_i = 5'd7;
    raddr2_i = 5'd2;
    #1;
    chk("rf_x7", rdata1_o, 64'h11);
    chk("rf_x2", rdata2_o, 64'd0);

    mem(5'd3, 1'b1, 64'h22);
    step();
    mem(5'd3, 1'b1, 64'h33);
    step();
    mem(5'd0, 1'b0, 64'd0);
    raddr1_i = 5'd3;
    raddr2_i = 5'd3;
    #1;
    chk("dual_cnt", commit_cnt_o, 64'd6);
    chk("dual_p1", rdata1_o, 64'h33);
    chk("dual_p2", rdata2_o, 64'h33);
    re2_i = 1'b0;
    #1;
    chk("re2_off", rdata2_o, 64'd0);
    chk("re2_p1", rdata1_o, 64'h33);
    step();
    re2_i = 1'b1;
    #1;
    chk("rf_x3", rdata2_o, 64'h33);
    chk("x3_cnt", commit_cnt_o, 64'd7);

    mem(5'd9, 1'b1, 64'h55);
    step();
    mem(5'd0, 1'b0, 64'd0);
    raddr1_i = 5'd9;
    #1;
    chk("x9_byp", rdata1_o, 64'h55);
    rst = 1'b1;
    #1;
    chk("rst_rd_byp", rdata1_o, 64'd0);
    step();
    chk("rst2_cnt", commit_cnt_o, 64'd0);
    chk("rst2_wreg", {63'd0, wb_wreg_o}, 64'd0);
    rst = 1'b0;
    step();
    chk("rst2_x9", rdata1_o, 64'd0);
    raddr2_i = 5'd3;
    #1;
    chk("rst2_x3", rdata2_o, 64'd0);
    chk("rst2_cnt2", commit_cnt_o, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
